// File: rtl/daq_arm_scheduler.sv
// daq_arm_scheduler: windowed ARM sequencer with two-channel result capture and round-robin readout
module daq_arm_scheduler #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 16
) (
  input  logic             s00_axi_aclk,
  input  logic             s00_axi_aresetn,
  input  logic             I_START,
  input  logic             I_ABORT,
  input  logic [WIN_W-1:0] I_WIN_LEN,
  input  logic [WIN_W-1:0] I_GAP_LEN,
  input  logic [7:0]       I_NUM_WIN,
  input  logic             I_READY_0,
  input  logic             I_READY_1,
  input  logic [CNT_W-1:0] I_CNT_A0,
  input  logic [CNT_W-1:0] I_CNT_A1,
  input  logic             I_OVERFLOW_0,
  input  logic             I_OVERFLOW_1,
  input  logic             I_RES_ACK,
  output logic             O_ARM,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic [7:0]       O_WIN_IDX,
  output logic             O_RES_VALID,
  output logic             O_RES_CH,
  output logic [CNT_W-1:0] O_RES_CNT,
  output logic             O_RES_OVF,
  output logic             O_DROP_0,
  output logic             O_DROP_1
);
  typedef enum logic [1:0] {IDLE, ARM, GAP, FINISH} state_t;
  state_t state, state_n;
  logic [WIN_W-1:0] win_len, gap_len, timer, timer_n;
  logic [7:0] num_win, win_idx, win_idx_n;
  logic start_ok, arm_q;
  assign start_ok = I_START && !I_ABORT && state == IDLE && I_NUM_WIN != '0 && I_WIN_LEN != '0;
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    win_idx_n = win_idx;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (start_ok) begin
          state_n = ARM;
          win_idx_n = '0;
        end
      end
      ARM:
        if (timer == win_len - 1'b1) begin
          timer_n = '0;
          if (win_idx == num_win - 8'd1) state_n = FINISH;
          else if (gap_len == '0) win_idx_n = win_idx + 8'd1;
          else state_n = GAP;
        end
      GAP:
        if (timer == gap_len - 1'b1) begin
          timer_n = '0;
          state_n = ARM;
          win_idx_n = win_idx + 8'd1;
        end
      FINISH: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
    if (I_ABORT) begin
      state_n = IDLE;
      timer_n = '0;
    end
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state <= IDLE;
      timer <= '0;
      win_idx <= '0;
      win_len <= '0;
      gap_len <= '0;
      num_win <= '0;
      arm_q <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      win_idx <= win_idx_n;
      arm_q <= state_n == ARM;
      if (start_ok) begin
        win_len <= I_WIN_LEN;
        gap_len <= I_GAP_LEN;
        num_win <= I_NUM_WIN;
      end
    end
  end
  assign O_ARM = arm_q;
  assign O_BUSY = state != IDLE;
  assign O_DONE = state == FINISH;
  assign O_WIN_IDX = win_idx;
  // Capture path: one pending slot per channel, drained round-robin into the output register
  logic [1:0] rdy, rdy_q, edg, full, grant, ovf_in, slot_ovf, drop;
  logic [CNT_W-1:0] cnt_in [2];
  logic [CNT_W-1:0] slot_cnt [2];
  logic rr, sel, load, any;
  assign rdy = {I_READY_1, I_READY_0};
  assign ovf_in = {I_OVERFLOW_1, I_OVERFLOW_0};
  assign cnt_in[0] = I_CNT_A0;
  assign cnt_in[1] = I_CNT_A1;
  assign edg = rdy & ~rdy_q;
  assign load = !O_RES_VALID || I_RES_ACK;
  assign any = |full;
  assign sel = full[rr] ? rr : !rr;
  assign grant = (load && any) ? (2'b01 << sel) : 2'b00;
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rdy_q <= 2'b11;
      full <= '0;
      slot_ovf <= '0;
      drop <= '0;
      rr <= 1'b0;
      for (int i = 0; i < 2; i++) slot_cnt[i] <= '0;
      O_RES_VALID <= 1'b0;
      O_RES_CH <= 1'b0;
      O_RES_CNT <= '0;
      O_RES_OVF <= 1'b0;
    end else begin
      rdy_q <= rdy;
      for (int i = 0; i < 2; i++) begin
        if (edg[i] && (!full[i] || grant[i])) begin
          slot_cnt[i] <= cnt_in[i];
          slot_ovf[i] <= ovf_in[i];
          full[i] <= 1'b1;
        end else if (grant[i]) full[i] <= 1'b0;
        drop[i] <= (drop[i] && !start_ok) || (edg[i] && full[i] && !grant[i]);
      end
      if (load) begin
        O_RES_VALID <= any;
        if (any) begin
          O_RES_CH <= sel;
          O_RES_CNT <= slot_cnt[sel];
          O_RES_OVF <= slot_ovf[sel];
          rr <= !sel;
        end
      end
    end
  end
  assign O_DROP_0 = drop[0];
  assign O_DROP_1 = drop[1];
endmodule

// File: tb/tb_daq_arm_scheduler.sv
// tb_daq_arm_scheduler: directed scenario checks for daq_arm_scheduler
module tb_daq_arm_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic I_START = 0, I_ABORT = 0, I_READY_0 = 0, I_READY_1 = 0;
  logic I_OVERFLOW_0 = 0, I_OVERFLOW_1 = 0, I_RES_ACK = 0;
  logic [15:0] I_WIN_LEN = 0, I_GAP_LEN = 0;
  logic [7:0] I_NUM_WIN = 0;
  logic [31:0] I_CNT_A0 = 0, I_CNT_A1 = 0;
  logic O_ARM, O_BUSY, O_DONE, O_RES_VALID, O_RES_CH, O_RES_OVF, O_DROP_0, O_DROP_1;
  logic [7:0] O_WIN_IDX;
  logic [31:0] O_RES_CNT;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  daq_arm_scheduler #(.CNT_W(32), .WIN_W(16)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .I_START(I_START), .I_ABORT(I_ABORT),
    .I_WIN_LEN(I_WIN_LEN), .I_GAP_LEN(I_GAP_LEN), .I_NUM_WIN(I_NUM_WIN),
    .I_READY_0(I_READY_0), .I_READY_1(I_READY_1), .I_CNT_A0(I_CNT_A0), .I_CNT_A1(I_CNT_A1),
    .I_OVERFLOW_0(I_OVERFLOW_0), .I_OVERFLOW_1(I_OVERFLOW_1), .I_RES_ACK(I_RES_ACK),
    .O_ARM(O_ARM), .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_WIN_IDX(O_WIN_IDX),
    .O_RES_VALID(O_RES_VALID), .O_RES_CH(O_RES_CH), .O_RES_CNT(O_RES_CNT), .O_RES_OVF(O_RES_OVF),
    .O_DROP_0(O_DROP_0), .O_DROP_1(O_DROP_1)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_seq(input logic [15:0] w, input logic [15:0] g, input logic [7:0] n);
    I_WIN_LEN = w;
    I_GAP_LEN = g;
    I_NUM_WIN = n;
    I_START = 1;
    tick;
    I_START = 0;
  endtask
  task automatic test_reset;
    repeat (3) tick;
    total++;
    if ({O_ARM, O_BUSY, O_DONE, O_RES_VALID, O_DROP_0, O_DROP_1} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 000000", {O_ARM, O_BUSY, O_DONE, O_RES_VALID, O_DROP_0, O_DROP_1});
    end
    total++;
    if (O_WIN_IDX !== 8'd0 || O_RES_CNT !== 32'd0) begin
      bad++;
      $display("FAIL reset_words got idx=%0d cnt=%0d want 0 0", O_WIN_IDX, O_RES_CNT);
    end
    rst_n = 1;
    tick;
  endtask
  task automatic test_ignored_start;
    start_seq(16'd5, 16'd0, 8'd0);
    total++;
    if (O_BUSY !== 1'b0) begin bad++; $display("FAIL start_num0 busy got %b want 0", O_BUSY); end
    start_seq(16'd0, 16'd3, 8'd2);
    total++;
    if (O_BUSY !== 1'b0) begin bad++; $display("FAIL start_win0 busy got %b want 0", O_BUSY); end
    I_ABORT = 1;
    start_seq(16'd5, 16'd0, 8'd1);
    I_ABORT = 0;
    total++;
    if (O_BUSY !== 1'b0 || O_ARM !== 1'b0) begin bad++; $display("FAIL abort_over_start busy=%b arm=%b want 0 0", O_BUSY, O_ARM); end
  endtask
  task automatic test_sequence;
    int hi, lo;
    start_seq(16'd250, 16'd250, 8'd5);
    for (int w = 0; w < 5; w++) begin
      hi = 0;
      repeat (250) begin
        if (O_ARM === 1'b1 && O_WIN_IDX === 8'(w) && O_DONE === 1'b0) hi++;
        tick;
      end
      total++;
      if (hi != 250) begin bad++; $display("FAIL seq_win%0d arm_cycles got %0d want 250", w, hi); end
      if (w < 4) begin
        lo = 0;
        repeat (250) begin
          if (O_ARM === 1'b0 && O_BUSY === 1'b1 && O_DONE === 1'b0) lo++;
          tick;
        end
        total++;
        if (lo != 250) begin bad++; $display("FAIL seq_gap%0d low_cycles got %0d want 250", w, lo); end
      end
    end
    total++;
    if (O_DONE !== 1'b1 || O_ARM !== 1'b0 || O_BUSY !== 1'b1) begin
      bad++;
      $display("FAIL seq_done done=%b arm=%b busy=%b want 1 0 1", O_DONE, O_ARM, O_BUSY);
    end
    tick;
    total++;
    if (O_DONE !== 1'b0 || O_BUSY !== 1'b0) begin bad++; $display("FAIL seq_idle done=%b busy=%b want 0 0", O_DONE, O_BUSY); end
  endtask
  task automatic test_zero_gap;
    int hi;
    start_seq(16'd10, 16'd0, 8'd3);
    I_WIN_LEN = 16'd3;
    I_NUM_WIN = 8'd1;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      I_START = (i == 5);
      if (O_ARM === 1'b1 && O_WIN_IDX === 8'(i / 10) && O_DONE === 1'b0) hi++;
      tick;
    end
    I_START = 0;
    total++;
    if (hi != 30) begin bad++; $display("FAIL zgap arm_cycles got %0d want 30", hi); end
    total++;
    if (O_DONE !== 1'b1 || O_ARM !== 1'b0) begin bad++; $display("FAIL zgap_done done=%b arm=%b want 1 0", O_DONE, O_ARM); end
    tick;
  endtask
  task automatic test_abort;
    int dn;
    start_seq(16'd250, 16'd250, 8'd5);
    repeat (1000) tick;
    total++;
    if (O_WIN_IDX !== 8'd2 || O_ARM !== 1'b1) begin bad++; $display("FAIL abort_win2 idx=%0d arm=%b want 2 1", O_WIN_IDX, O_ARM); end
    repeat (100) tick;
    I_ABORT = 1;
    tick;
    I_ABORT = 0;
    total++;
    if (O_ARM !== 1'b0 || O_BUSY !== 1'b0 || O_DONE !== 1'b0) begin
      bad++;
      $display("FAIL abort_stop arm=%b busy=%b done=%b want 0 0 0", O_ARM, O_BUSY, O_DONE);
    end
    dn = 0;
    repeat (600) begin
      if (O_DONE !== 1'b0 || O_ARM !== 1'b0) dn++;
      tick;
    end
    total++;
    if (dn != 0) begin bad++; $display("FAIL abort_quiet active_cycles got %0d want 0", dn); end
  endtask
  task automatic test_simul_ready;
    I_RES_ACK = 1;
    I_CNT_A0 = 3;
    I_CNT_A1 = 7;
    I_OVERFLOW_1 = 1;
    I_READY_0 = 1;
    I_READY_1 = 1;
    tick;
    total++;
    if (O_RES_VALID !== 1'b0) begin bad++; $display("FAIL sim_latency valid got %b want 0", O_RES_VALID); end
    tick;
    total++;
    if ({O_RES_VALID, O_RES_CH, O_RES_OVF} !== 3'b100 || O_RES_CNT !== 32'd3) begin
      bad++;
      $display("FAIL sim_first v/ch/ovf=%b cnt=%0d want 100 3", {O_RES_VALID, O_RES_CH, O_RES_OVF}, O_RES_CNT);
    end
    tick;
    total++;
    if ({O_RES_VALID, O_RES_CH, O_RES_OVF} !== 3'b111 || O_RES_CNT !== 32'd7) begin
      bad++;
      $display("FAIL sim_second v/ch/ovf=%b cnt=%0d want 111 7", {O_RES_VALID, O_RES_CH, O_RES_OVF}, O_RES_CNT);
    end
    tick;
    total++;
    if (O_RES_VALID !== 1'b0) begin bad++; $display("FAIL sim_empty valid got %b want 0", O_RES_VALID); end
    I_READY_0 = 0;
    I_READY_1 = 0;
    I_OVERFLOW_1 = 0;
    tick;
    I_CNT_A0 = 11;
    I_CNT_A1 = 13;
    I_READY_0 = 1;
    I_READY_1 = 1;
    tick;
    tick;
    total++;
    if (O_RES_VALID !== 1'b1 || O_RES_CH !== 1'b0 || O_RES_CNT !== 32'd11) begin
      bad++;
      $display("FAIL sim_pair2_first v=%b ch=%b cnt=%0d want 1 0 11", O_RES_VALID, O_RES_CH, O_RES_CNT);
    end
    tick;
    total++;
    if (O_RES_VALID !== 1'b1 || O_RES_CH !== 1'b1 || O_RES_CNT !== 32'd13) begin
      bad++;
      $display("FAIL sim_pair2_second v=%b ch=%b cnt=%0d want 1 1 13", O_RES_VALID, O_RES_CH, O_RES_CNT);
    end
    I_READY_0 = 0;
    I_READY_1 = 0;
    tick;
    tick;
  endtask
  task automatic test_backpressure;
    I_RES_ACK = 0;
    for (int k = 0; k < 3; k++) begin
      I_CNT_A0 = 32'(21 + k);
      I_READY_0 = 1;
      tick;
      I_READY_0 = 0;
      tick;
      total++;
      if (O_RES_VALID !== 1'b1 || O_RES_CNT !== 32'd21) begin
        bad++;
        $display("FAIL bp_hold%0d v=%b cnt=%0d want 1 21", k, O_RES_VALID, O_RES_CNT);
      end
    end
    total++;
    if (O_DROP_0 !== 1'b1 || O_DROP_1 !== 1'b0) begin bad++; $display("FAIL bp_drop d0=%b d1=%b want 1 0", O_DROP_0, O_DROP_1); end
    I_RES_ACK = 1;
    tick;
    total++;
    if (O_RES_VALID !== 1'b1 || O_RES_CNT !== 32'd22) begin bad++; $display("FAIL bp_slot v=%b cnt=%0d want 1 22", O_RES_VALID, O_RES_CNT); end
    tick;
    total++;
    if (O_RES_VALID !== 1'b0) begin bad++; $display("FAIL bp_drain valid got %b want 0", O_RES_VALID); end
    total++;
    if (O_DROP_0 !== 1'b1) begin bad++; $display("FAIL bp_sticky d0 got %b want 1", O_DROP_0); end
    start_seq(16'd4, 16'd0, 8'd1);
    total++;
    if (O_DROP_0 !== 1'b0 || O_ARM !== 1'b1) begin bad++; $display("FAIL bp_clear d0=%b arm=%b want 0 1", O_DROP_0, O_ARM); end
    repeat (8) tick;
  endtask
  task automatic test_reset_mid;
    int seen;
    I_RES_ACK = 0;
    start_seq(16'd50, 16'd10, 8'd3);
    repeat (5) tick;
    for (int k = 0; k < 2; k++) begin
      I_CNT_A1 = 32'(99 + k);
      I_READY_1 = 1;
      tick;
      I_READY_1 = 0;
      tick;
    end
    total++;
    if (O_ARM !== 1'b1 || O_RES_VALID !== 1'b1 || O_RES_CNT !== 32'd99) begin
      bad++;
      $display("FAIL rst_pre arm=%b v=%b cnt=%0d want 1 1 99", O_ARM, O_RES_VALID, O_RES_CNT);
    end
    rst_n = 0;
    #2;
    total++;
    if ({O_ARM, O_BUSY, O_DONE, O_RES_VALID, O_RES_CH, O_RES_OVF} !== 6'b0 || O_RES_CNT !== 32'd0 || O_WIN_IDX !== 8'd0) begin
      bad++;
      $display("FAIL rst_async flags=%b cnt=%0d idx=%0d want 000000 0 0",
               {O_ARM, O_BUSY, O_DONE, O_RES_VALID, O_RES_CH, O_RES_OVF}, O_RES_CNT, O_WIN_IDX);
    end
    I_READY_0 = 1;
    I_RES_ACK = 1;
    tick;
    tick;
    rst_n = 1;
    seen = 0;
    repeat (6) begin
      tick;
      if (O_RES_VALID !== 1'b0 || O_ARM !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL rst_release active_cycles got %0d want 0", seen); end
    I_READY_0 = 0;
    tick;
    I_CNT_A0 = 55;
    I_READY_0 = 1;
    tick;
    tick;
    total++;
    if (O_RES_VALID !== 1'b1 || O_RES_CH !== 1'b0 || O_RES_CNT !== 32'd55) begin
      bad++;
      $display("FAIL rst_after v=%b ch=%b cnt=%0d want 1 0 55", O_RES_VALID, O_RES_CH, O_RES_CNT);
    end
    I_READY_0 = 0;
    tick;
  endtask
  initial begin
    test_reset;
    test_ignored_start;
    test_sequence;
    test_zero_gap;
    test_abort;
    test_simul_ready;
    test_backpressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
